alu_share_arbiter: RTL and testbench

Shares one combinational ALU between NUM_REQ requesters, for example an integer issue port and an address/branch helper.
- Arbitration is round-robin: at most one operation is granted per cycle.
- The block drives the shared ALU operand and funct lines from the granted requester.
- It captures the ALU result into a per-requester response register.
- Responses are returned through a valid/ready handshake.
- It sits between the issue stage(s) and the ALU instance inside mycpu.

---
 rtl/alu_share_arbiter_if.sv | 40 ++++
 rtl/alu_share_arbiter.sv | 110 +++++++++++
 tb/tb_alu_share_arbiter.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/alu_share_arbiter_if.sv
// Bus bundle between the requesters, the shared-ALU arbiter and the ALU itself.
// ALU_ARB_PERF_EN adds the per-requester grant counter output.
interface alu_share_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int W       = 32
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*W-1:0] req_in1;
  logic [NUM_REQ*W-1:0] req_in2;
  logic [NUM_REQ*5-1:0] req_shamt;
  logic [NUM_REQ*6-1:0] req_funct;
  logic [W-1:0]         alu_in1;
  logic [W-1:0]         alu_in2;
  logic [4:0]           alu_shamt;
  logic [5:0]           alu_funct;
  logic [W-1:0]         alu_out;
  logic [NUM_REQ-1:0]   resp_valid;
  logic [NUM_REQ*W-1:0] resp_data;
  logic [NUM_REQ-1:0]   resp_ready;
`ifdef ALU_ARB_PERF_EN
  logic [NUM_REQ*32-1:0] perf_grant_cnt;
`endif

  modport slave (
    input  req_valid, req_in1, req_in2, req_shamt, req_funct, alu_out, resp_ready,
    output req_ready, alu_in1, alu_in2, alu_shamt, alu_funct, resp_valid, resp_data
`ifdef ALU_ARB_PERF_EN
    , output perf_grant_cnt
`endif
  );

  modport master (
    output req_valid, req_in1, req_in2, req_shamt, req_funct, alu_out, resp_ready,
    input  req_ready, alu_in1, alu_in2, alu_shamt, alu_funct, resp_valid, resp_data
`ifdef ALU_ARB_PERF_EN
    , input perf_grant_cnt
`endif
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NUM_REQ requesters,
// with a registered response slot each. ALU_ARB_PERF_EN adds saturating grant counters.
module alu_share_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int W       = 32
) (
  input logic            clk,
  input logic            reset,
  alu_share_arbiter_if.slave bus
);
  localparam int IDX_W = (NUM_REQ > 2) ? 2 : 1;
  typedef logic [IDX_W-1:0] idx_t;
  localparam idx_t LAST_RST = idx_t'(NUM_REQ - 1);

  logic [NUM_REQ-1:0]        resp_valid_q, resp_valid_d;
  logic [NUM_REQ-1:0][W-1:0] resp_data_q, resp_data_d;
  idx_t                      last_grant_q, last_grant_d;
  logic [NUM_REQ-1:0]        elig_s;
  logic [NUM_REQ-1:0]        grant_s;
  logic                      grant_any_s;
  logic                      grant_en_s;
  logic                      hit_s;
  idx_t                      grant_idx_s;

  function automatic idx_t next_idx(input idx_t base, input int k);
    return idx_t'((int'(base) + k) % NUM_REQ);
  endfunction

  // Eligibility and round-robin search starting just after the last grant.
  always_comb begin
    elig_s      = bus.req_valid & (~resp_valid_q | bus.resp_ready);
    grant_any_s = 1'b0;
    grant_idx_s = last_grant_q;
    hit_s       = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      hit_s       = ~grant_any_s & elig_s[next_idx(last_grant_q, k)];
      grant_idx_s = hit_s ? next_idx(last_grant_q, k) : grant_idx_s;
      grant_any_s = grant_any_s | hit_s;
    end
    grant_en_s = grant_any_s & ~reset;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_s[i] = grant_en_s & (grant_idx_s == idx_t'(i));
    end
  end

  // Shared ALU operands follow the granted requester, zero when idle.
  always_comb begin
    if (grant_en_s) begin
      bus.alu_in1   = bus.req_in1[int'(grant_idx_s)*W +: W];
      bus.alu_in2   = bus.req_in2[int'(grant_idx_s)*W +: W];
      bus.alu_shamt = bus.req_shamt[int'(grant_idx_s)*5 +: 5];
      bus.alu_funct = bus.req_funct[int'(grant_idx_s)*6 +: 6];
    end else begin
      bus.alu_in1   = {W{1'b0}};
      bus.alu_in2   = {W{1'b0}};
      bus.alu_shamt = 5'd0;
      bus.alu_funct = 6'd0;
    end
  end

  // Response slots: a grant loads the ALU result, a consumed slot empties.
  always_comb begin
    last_grant_d = grant_en_s ? grant_idx_s : last_grant_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      resp_valid_d[i] = (resp_valid_q[i] & ~bus.resp_ready[i]) | grant_s[i];
      resp_data_d[i]  = grant_s[i] ? bus.alu_out : resp_data_q[i];
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid_q <= {NUM_REQ{1'b0}};
      resp_data_q  <= '0;
      last_grant_q <= LAST_RST;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign bus.req_ready  = grant_s;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;

`ifdef ALU_ARB_PERF_EN
  logic [NUM_REQ-1:0][31:0] perf_cnt_q, perf_cnt_d;

  // Grant counters stick at all-ones instead of wrapping.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      perf_cnt_d[i] = (grant_s[i] && (perf_cnt_q[i] != 32'hFFFF_FFFF)) ?
                      perf_cnt_q[i] + 32'd1 : perf_cnt_q[i];
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_cnt_q <= '0;
    end else begin
      perf_cnt_q <= perf_cnt_d;
    end
  end

  assign bus.perf_grant_cnt = perf_cnt_q;
`else
`endif
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: a reference arbitration model predicts
// grants, expected ALU results are queued at grant and compared when consumed.
module tb_alu_share_arbiter;
  localparam int N = 2;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_share_arbiter_if #(.NUM_REQ(N), .W(W)) bus ();
  alu_share_arbiter #(.NUM_REQ(N), .W(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  function automatic logic [31:0] alu_f(input logic [5:0] f, input logic [31:0] a,
                                        input logic [31:0] b, input logic [4:0] sh);
    case (f)
      6'h00:   return b << sh;
      6'h02:   return b >> sh;
      6'h03:   return unsigned'($signed(b) >>> sh);
      6'h21:   return a + b;
      6'h23:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      6'h2A:   return {31'd0, ($signed(a) < $signed(b))};
      6'h2B:   return {31'd0, (a < b)};
      default: return a ^ b ^ {26'd0, f};
    endcase
  endfunction

  // Shared ALU stand-in.
  always_comb bus.alu_out = alu_f(bus.alu_funct, bus.alu_in1, bus.alu_in2, bus.alu_shamt);

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [31:0] sb [N][$];
  logic [N-1:0] m_valid = '0;
  int           m_last  = N - 1;
  logic [N-1:0] pend    = '0;
  logic [N-1:0] v, rr;
  logic [31:0]  a_in1 [N];
  logic [31:0]  a_in2 [N];
  logic [4:0]   a_sh  [N];
  logic [5:0]   a_f   [N];
  logic [5:0]   flist [0:11] = '{6'h00, 6'h02, 6'h03, 6'h21, 6'h23, 6'h24,
                                 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h3F};

  task automatic set_op(input int i, input logic [5:0] f, input logic [31:0] x,
                        input logic [31:0] y, input logic [4:0] s);
    a_f[i] = f; a_in1[i] = x; a_in2[i] = y; a_sh[i] = s;
  endtask

  // One cycle: drive at negedge, compare mid-cycle, update model after the edge.
  task automatic step(input logic rst);
    logic [N-1:0] exp_gnt;
    int gidx;
    int c;
    reset = rst;
    bus.req_valid  = v;
    bus.resp_ready = rr;
    for (int i = 0; i < N; i++) begin
      bus.req_in1[i*W +: W]   = a_in1[i];
      bus.req_in2[i*W +: W]   = a_in2[i];
      bus.req_shamt[i*5 +: 5] = a_sh[i];
      bus.req_funct[i*6 +: 6] = a_f[i];
    end
    #1;
    exp_gnt = '0;
    gidx = -1;
    if (!rst) begin
      for (int k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (gidx < 0 && v[c] && (!m_valid[c] || rr[c])) gidx = c;
      end
    end
    if (gidx >= 0) exp_gnt[gidx] = 1'b1;
    check_eq("req_ready", 64'(bus.req_ready), 64'(exp_gnt));
    check_eq("alu_in1", 64'(bus.alu_in1), (gidx >= 0) ? 64'(a_in1[gidx]) : 64'd0);
    check_eq("alu_funct", 64'(bus.alu_funct), (gidx >= 0) ? 64'(a_f[gidx]) : 64'd0);
    check_eq("resp_valid", 64'(bus.resp_valid), 64'(m_valid));
    for (int i = 0; i < N; i++) begin
      if (m_valid[i]) begin
        check_eq("sb_size", 64'(sb[i].size()), 64'd1);
        if (sb[i].size() > 0) begin
          check_eq("resp_data", 64'(bus.resp_data[i*W +: W]), 64'(sb[i][0]));
          if (rr[i]) void'(sb[i].pop_front());
        end
      end
    end
    if (gidx >= 0) sb[gidx].push_back(alu_f(a_f[gidx], a_in1[gidx], a_in2[gidx], a_sh[gidx]));
    @(posedge clk);
    if (rst) begin
      m_valid = '0;
      m_last  = N - 1;
      for (int i = 0; i < N; i++) sb[i].delete();
    end else begin
      m_valid = (m_valid & ~rr) | exp_gnt;
      if (gidx >= 0) m_last = gidx;
    end
    pend = v & ~exp_gnt;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    v = '0; rr = '0;
    for (int i = 0; i < N; i++) set_op(i, 6'h00, 32'd0, 32'd0, 5'd0);
    @(negedge clk);
    step(1'b1);
    v = 2'b11;
    step(1'b1);
    check_eq("rst_resp_data", 64'(bus.resp_data), 64'd0);

    // Single requester ADDU.
    v = 2'b01; rr = 2'b11;
    set_op(0, 6'h21, 32'h0000_0005, 32'h0000_0003, 5'd0);
    step(1'b0);
    v = 2'b00;
    step(1'b0);

    // Both requesters streaming, grants alternate from 0.
    step(1'b1);
    set_op(0, 6'h23, 32'd10, 32'd3, 5'd0);
    set_op(1, 6'h25, 32'h0000_00F0, 32'h0000_000F, 5'd0);
    v = 2'b11; rr = 2'b11;
    repeat (4) step(1'b0);

    // Back-pressure on requester 0, then drain-and-refill with SLT.
    v = 2'b01; rr = 2'b00;
    step(1'b0);
    set_op(0, 6'h2A, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0);
    v = 2'b11; rr = 2'b10;
    repeat (3) step(1'b0);
    rr = 2'b11;
    step(1'b0);
    v = 2'b00;
    step(1'b0);

    // Reset while requester 1 is asking; first grant afterwards goes to 0.
    v = 2'b10; rr = 2'b00;
    step(1'b0);
    step(1'b1);
    check_eq("midrst_valid", 64'(bus.resp_valid), 64'd0);
    check_eq("midrst_data", 64'(bus.resp_data), 64'd0);
    v = 2'b11; rr = 2'b11;
    step(1'b0);

    // Random traffic, holding operands of any requester still waiting.
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i]) begin
          v[i] = 1'($urandom_range(0, 1));
          set_op(i, flist[$urandom_range(0, 11)], $urandom, $urandom, 5'($urandom_range(0, 31)));
        end
      end
      rr = N'($urandom_range(0, 3));
      step(1'b0);
    end
    v = '0; rr = '1;
    repeat (2) step(1'b0);

`ifdef ALU_ARB_PERF_EN
    step(1'b1);
    rr = 2'b11;
    v = 2'b01;
    repeat (5) step(1'b0);
    v = 2'b10;
    repeat (3) step(1'b0);
    v = 2'b00;
    step(1'b0);
    check_eq("perf0", 64'(bus.perf_grant_cnt[31:0]), 64'd5);
    check_eq("perf1", 64'(bus.perf_grant_cnt[63:32]), 64'd3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
